// File: rtl/memoria_nrisc.sv
// memoria_nrisc: instruction/data memory responder for the nRisc core,
// filled by a byte-stream loader before the core is allowed to run.
module memoria_nrisc #(
   parameter int PROF_INSTR = 256,
   parameter int PROF_DADOS = 256
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic [7:0] SaidaPC,
   output logic [7:0] Instrucao,
   input  logic [7:0] EndMemDados,
   input  logic [7:0] DadoEscritoMem,
   input  logic       EscMem,
   input  logic       LerMem,
   output logic [7:0] DadoLidoMem,
   input  logic       CargaValido,
   input  logic [7:0] CargaDado,
   input  logic       CargaSel,
   input  logic       CargaFim,
   output logic       CargaPronto,
   output logic       Executando,
   output logic       ErroCarga
);
   localparam int AI = $clog2(PROF_INSTR);
   localparam int AD = $clog2(PROF_DADOS);
   localparam logic [7:0] FIM_I = 8'(PROF_INSTR - 1);
   localparam logic [7:0] FIM_D = 8'(PROF_DADOS - 1);

   typedef enum logic {CARGA, EXEC} estado_t;

   estado_t       estado, prox;
   logic [7:0]    imem [PROF_INSTR];
   logic [7:0]    dmem [PROF_DADOS];
   logic [7:0]    cont_i, cont_d;
   logic          exec, aceita, ult_i, ult_d, esc_d;
   logic [AD-1:0] end_d;
   logic [7:0]    dado_d;

   always_comb begin
      exec   = (estado == EXEC);
      aceita = CargaValido & ~exec;
      ult_i  = (cont_i == FIM_I);
      ult_d  = (cont_d == FIM_D);
      prox   = (!exec && aceita && CargaFim) ? EXEC : estado;
      // the data port is shared: loader owns it in CARGA, the core in EXEC
      esc_d  = exec ? EscMem : (aceita & CargaSel);
      end_d  = exec ? EndMemDados[AD-1:0] : cont_d[AD-1:0];
      dado_d = exec ? DadoEscritoMem : CargaDado;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         estado    <= CARGA;
         cont_i    <= 8'd0;
         cont_d    <= 8'd0;
         ErroCarga <= 1'b0;
      end else begin
         estado <= prox;
         if (aceita && !CargaSel) cont_i <= ult_i ? 8'd0 : cont_i + 8'd1;
         if (aceita && CargaSel) cont_d <= ult_d ? 8'd0 : cont_d + 8'd1;
         if (aceita && (CargaSel ? ult_d : ult_i)) ErroCarga <= 1'b1;
      end
   end

   // arrays keep their contents across reset
   always_ff @(posedge Clock) begin
      if (aceita && !CargaSel) imem[cont_i[AI-1:0]] <= CargaDado;
      if (esc_d) dmem[end_d] <= dado_d;
   end

   assign Executando  = exec;
   assign CargaPronto = ~exec;
   assign Instrucao   = exec ? imem[SaidaPC[AI-1:0]] : 8'h00;
   assign DadoLidoMem = (exec && LerMem) ? dmem[EndMemDados[AD-1:0]] : 8'h00;
endmodule

// File: doc/memoria_nrisc.md
# memoria_nrisc

Instruction and data memory responder for the nRisc core: the other end of the core's fetch and load/store interface. It answers `SaidaPC` with `Instrucao` and serves `EndMemDados`/`DadoEscritoMem`/`DadoLidoMem` with the single-cycle timing the core expects. Before execution, a byte-stream loader fills both memories through a valid/ready handshake. A two-state FSM holds the core off (`Executando`=0) until loading completes.

## Interface
- `PROF_INSTR`, default 256: instruction-memory depth in bytes. Power of two, at most 256.
- `PROF_DADOS`, default 256: data-memory depth in bytes. Power of two, at most 256.
- `Clock`  in  1  single clock, rising-edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `SaidaPC`  in  8  instruction fetch address from the core.
- `Instrucao`  out  8  instruction byte returned to the core.
- `EndMemDados`  in  8  data address from the core.
- `DadoEscritoMem`  in  8  store data from the core.
- `EscMem`  in  1  store strobe from the core.
- `LerMem`  in  1  load strobe from the core.
- `DadoLidoMem`  out  8  load data returned to the core.
- `CargaValido`  in  1  loader byte valid.
- `CargaDado`  in  8  loader byte.
- `CargaSel`  in  1  loader target: 0 = instruction memory, 1 = data memory.
- `CargaFim`  in  1  marks the final loader byte.
- `CargaPronto`  out  1  loader ready.
- `Executando`  out  1  core may run. Drives the core's clock-enable/PC gating.
- `ErroCarga`  out  1  sticky loader overflow flag.

## Operation
- FSM states: CARGA (reset state) and EXEC.
- CARGA to EXEC: on an accepted loader byte with `CargaFim`=1.
- EXEC to CARGA: only through reset.
- `CargaPronto` = 1 in CARGA and 0 in EXEC. It is decoded from state only, with no dependence on `CargaValido`.
- A loader byte is accepted on a rising edge when `CargaValido`=1 and `CargaPronto`=1. The byte goes to memory[`CargaSel`][counter], and that counter increments.
- Each memory has its own 8-bit load counter (`ContI`, `ContD`). Counter address is taken modulo the memory depth.
- Overflow: accepting a byte while the target counter = depth−1 writes the byte, wraps the counter to 0 and sets `ErroCarga`. `ErroCarga` stays set until reset. Loading continues after overflow.
- Fetch: `Instrucao` = imem[`SaidaPC` mod `PROF_INSTR`] in EXEC (combinational read). `Instrucao` = 8'h00 in CARGA.
- Load: `DadoLidoMem` = dmem[`EndMemDados` mod `PROF_DADOS`] when in EXEC and `LerMem`=1. Otherwise `DadoLidoMem` = 8'h00.
- Store: dmem[`EndMemDados` mod `PROF_DADOS`] ← `DadoEscritoMem` on a rising edge when in EXEC and `EscMem`=1.
- `EscMem` and `LerMem` are ignored in CARGA.
- Same-cycle store and load to the same address: `DadoLidoMem` shows the old value during that cycle and the new value after the edge.
- `EscMem` and `LerMem` both high: both actions are performed, with no error.
- Reset (asserted at any time, including mid-load or mid-execution) forces state to CARGA, `ContI`=`ContD`=0 and `ErroCarga`=0. Memory arrays are not cleared.

## Timing
- Reset values: `Executando`=0, `CargaPronto`=1, `ErroCarga`=0, `Instrucao`=8'h00, `DadoLidoMem`=8'h00.
- Reset assertion takes effect immediately (asynchronous). Deassertion is sampled at the next rising edge.
- Loader throughput: one byte per cycle.
- The `CargaFim` byte is written, and `Executando`/`CargaPronto` change, at the same rising edge.
- Fetch and load reads have zero-cycle latency (combinational from address). Stores complete at the edge.
- The first valid `Instrucao` appears in the cycle after the `CargaFim` acceptance edge.

## Test plan
- Reset: pulse `Reset_n` low mid-cycle. Required: `Executando`=0, `CargaPronto`=1, `Instrucao`=00 and `ErroCarga`=0 immediately, without waiting for a clock edge.
- Instruction load: stream A1, B2, C3 (`CargaSel`=0), with C3 carrying `CargaFim`. Required: `Executando`=1 from the next cycle. `SaidaPC`=0/1/2 yields A1/B2/C3.
- Data load and store: preload dmem[0]=5A (`CargaSel`=1), then load an instruction byte with `CargaFim`. In EXEC, `LerMem`@0 returns 5A. Store 3C@0 together with `LerMem`@0: returns 5A in that cycle and 3C in the next. Required: `LerMem`=0 gives `DadoLidoMem`=00.
- Gated access: in CARGA, drive `EscMem`=1 to address 7 with data FF. After finishing the load, read address 7. Required: the preloaded value, not FF.
- Overflow: with `PROF_INSTR`=4, load 5 instruction bytes 10..14. Required: `ErroCarga`=1 after the 5th byte, and imem[0]=14.
- Reset mid-load: load 2 bytes, reset, then load 1 byte with `CargaFim`. Required: the new byte lands at address 0, and `Executando` rises only after it is accepted.
